// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter for the dual-issue memory stage.
// Serialises lane accesses onto one port and stalls until both lanes are done.
module dmem_port_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemReq1,
  input  logic        MemReq2,
  input  logic        MemWrite1,
  input  logic        MemWrite2,
  input  logic [31:0] Addr1,
  input  logic [31:0] Addr2,
  input  logic [31:0] WData1,
  input  logic [31:0] WData2,
  input  logic [2:0]  Size1,
  input  logic [2:0]  Size2,
  output logic        MemValid,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [2:0]  MemSize,
  input  logic        MemReady,
  input  logic        MemRespValid,
  input  logic [31:0] MemRData,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2,
  output logic        Done1,
  output logic        Done2,
  output logic        StallMemory
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        grant_q;
  logic        served1_q;
  logic        served2_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  size_q;
  logic        pend1;
  logic        pend2;
  logic        done_g;
  logic        rd_load;
  logic        start;

  assign pend1 = MemReq1 & ~served1_q;
  assign pend2 = MemReq2 & ~served2_q;
  assign start = (state_q == IDLE) & (pend1 | pend2);

  // Next state, port valid and completion of the granted access.
  always_comb begin
    state_d  = state_q;
    MemValid = 1'b0;
    done_g   = 1'b0;
    rd_load  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend1 | pend2) state_d = ISSUE;
      end
      ISSUE: begin
        MemValid = 1'b1;
        if (MemReady) begin
          if (we_q) begin
            done_g  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (MemRespValid) begin
          done_g  = 1'b1;
          rd_load = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Done1       = done_g & ~grant_q;
  assign Done2       = done_g & grant_q;
  assign StallMemory = (pend1 & ~Done1) | (pend2 & ~Done2);

  // Request fields come from a latched copy so a dropped MemReq cannot disturb them.
  assign MemWe    = MemValid & we_q;
  assign MemAddr  = MemValid ? addr_q  : 32'd0;
  assign MemWData = MemValid ? wdata_q : 32'd0;
  assign MemSize  = MemValid ? size_q  : 3'd0;

  // State, grant and latched request of the lane being served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      size_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      if (start) begin
        grant_q <= ~pend1;
        we_q    <= pend1 ? MemWrite1 : MemWrite2;
        addr_q  <= pend1 ? Addr1     : Addr2;
        wdata_q <= pend1 ? WData1    : WData2;
        size_q  <= pend1 ? Size1     : Size2;
      end
    end
  end

  // Served flags stick until the pipeline advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      served1_q <= 1'b0;
      served2_q <= 1'b0;
    end else if (!StallMemory) begin
      served1_q <= 1'b0;
      served2_q <= 1'b0;
    end else begin
      if (Done1) served1_q <= 1'b1;
      if (Done2) served2_q <= 1'b1;
    end
  end

  // Load results, held until the next load of the same lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ReadData1 <= 32'd0;
      ReadData2 <= 32'd0;
    end else if (rd_load) begin
      if (!grant_q) ReadData1 <= MemRData;
      else          ReadData2 <= MemRData;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter.
// Timeline model per instruction pair, drives memory from that model.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req1, req2, we1, we2;
  logic [31:0] addr1, addr2, wd1, wd2;
  logic [2:0]  size1, size2;
  logic        MemValid, MemWe;
  logic [31:0] MemAddr, MemWData;
  logic [2:0]  MemSize;
  logic        MemReady, MemRespValid;
  logic [31:0] MemRData;
  logic [31:0] ReadData1, ReadData2;
  logic        Done1, Done2, StallMemory;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] rd_exp1, rd_exp2;
  bit          fix_en;
  logic [31:0] fix_data;

  always #5 clk = ~clk;

  dmem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .MemReq1(req1), .MemReq2(req2),
    .MemWrite1(we1), .MemWrite2(we2),
    .Addr1(addr1), .Addr2(addr2),
    .WData1(wd1), .WData2(wd2),
    .Size1(size1), .Size2(size2),
    .MemValid(MemValid), .MemWe(MemWe),
    .MemAddr(MemAddr), .MemWData(MemWData),
    .MemSize(MemSize),
    .MemReady(MemReady), .MemRespValid(MemRespValid),
    .MemRData(MemRData),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .Done1(Done1), .Done2(Done2),
    .StallMemory(StallMemory)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One instruction pair: build the expected cycle timeline from the
  // access list (IDLE 1, ISSUE 1+ready delay, WAIT 1+resp delay for loads),
  // act as memory from it and compare every cycle.
  task automatic run_pair(input int rd1, input int rs1, input int rd2,
                          input int rs2, input int drop2, input string tag);
    int nacc, total, t, hs;
    int al[2], ard[2], ars[2];
    bit ald[2];
    bit e_valid[64], e_ready[64], e_resp[64], e_wait[64];
    bit e_d1[64], e_d2[64];
    int e_lane[64];
    logic [67:0] exp_f, got_f;
    bit e_st;
    for (int i = 0; i < 64; i++) begin
      e_valid[i] = 0; e_ready[i] = 0; e_resp[i] = 0; e_wait[i] = 0;
      e_d1[i] = 0; e_d2[i] = 0; e_lane[i] = 0;
    end
    nacc = 0;
    if (req1) begin
      al[nacc] = 1; ald[nacc] = !we1;
      ard[nacc] = rd1; ars[nacc] = rs1; nacc++;
    end
    if (req2 && drop2 < 0) begin
      al[nacc] = 2; ald[nacc] = !we2;
      ard[nacc] = rd2; ars[nacc] = rs2; nacc++;
    end
    t = 0;
    for (int k = 0; k < nacc; k++) begin
      t++;
      for (int j = 0; j <= ard[k]; j++) begin
        e_valid[t] = 1; e_lane[t] = al[k]; t++;
      end
      e_ready[t-1] = 1;
      if (ald[k]) begin
        for (int j = 0; j <= ars[k]; j++) begin
          e_wait[t] = 1; e_lane[t] = al[k]; t++;
        end
        e_resp[t-1] = 1;
      end
      if (al[k] == 1) e_d1[t-1] = 1;
      else            e_d2[t-1] = 1;
    end
    total = (t == 0) ? 1 : t;
    hs = 0;
    for (int c = 0; c < total; c++) begin
      if (drop2 >= 0 && c >= drop2) req2 = 1'b0;
      MemReady     = e_valid[c] ? e_ready[c] : ($urandom_range(0, 1) == 1);
      MemRespValid = e_wait[c]  ? e_resp[c]  : ($urandom_range(0, 1) == 1);
      MemRData     = $urandom;
      if (e_resp[c]) begin
        if (fix_en) MemRData = fix_data;
        if (e_lane[c] == 1) rd_exp1 = MemRData;
        else                rd_exp2 = MemRData;
      end
      #1;
      compared++;
      if (MemValid !== e_valid[c]) begin
        mismatched++;
        $display("FAIL %s c%0d MemValid got %b exp %b", tag, c, MemValid, e_valid[c]);
      end
      compared++;
      if ({Done1, Done2} !== {e_d1[c], e_d2[c]}) begin
        mismatched++;
        $display("FAIL %s c%0d Done got %b%b exp %b%b", tag, c,
                 Done1, Done2, e_d1[c], e_d2[c]);
      end
      e_st = (c < total - 1);
      compared++;
      if (StallMemory !== e_st) begin
        mismatched++;
        $display("FAIL %s c%0d Stall got %b exp %b", tag, c, StallMemory, e_st);
      end
      if (e_valid[c]) begin
        exp_f = (e_lane[c] == 1) ? {we1, addr1, wd1, size1}
                                 : {we2, addr2, wd2, size2};
        got_f = {MemWe, MemAddr, MemWData, MemSize};
        compared++;
        if (got_f !== exp_f) begin
          mismatched++;
          $display("FAIL %s c%0d req fields got %h exp %h", tag, c, got_f, exp_f);
        end
      end
      if (MemValid && MemReady) hs++;
      tick();
    end
    MemReady     = 1'b0;
    MemRespValid = 1'b0;
    compared++;
    if (hs !== nacc) begin
      mismatched++;
      $display("FAIL %s handshakes got %0d exp %0d", tag, hs, nacc);
    end
    compared++;
    if (ReadData1 !== rd_exp1) begin
      mismatched++;
      $display("FAIL %s ReadData1 got %h exp %h", tag, ReadData1, rd_exp1);
    end
    compared++;
    if (ReadData2 !== rd_exp2) begin
      mismatched++;
      $display("FAIL %s ReadData2 got %h exp %h", tag, ReadData2, rd_exp2);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h5555_AAAA;
    wd1 = 32'h1234_5678; size1 = 3'd2;
    req2 = 1'b1; we2 = 1'b0; addr2 = 32'h0000_0FF0;
    wd2 = 32'h0; size2 = 3'd1;
    MemReady = 1'b1; MemRespValid = 1'b1; MemRData = 32'hFFFF_FFFF;
    fix_en = 0; fix_data = 32'd0;
    rd_exp1 = 32'd0; rd_exp2 = 32'd0;
    #3;
    compared++;
    if ({MemValid, MemWe, MemAddr, MemWData, MemSize, Done1, Done2} !== 72'd0) begin
      mismatched++;
      $display("FAIL reset port got %b %b %h %h %h %b%b", MemValid, MemWe,
               MemAddr, MemWData, MemSize, Done1, Done2);
    end
    compared++;
    if ({ReadData1, ReadData2} !== 64'd0) begin
      mismatched++;
      $display("FAIL reset readdata got %h %h exp 0", ReadData1, ReadData2);
    end
    @(posedge clk);
    #1;
    req1 = 1'b0; req2 = 1'b0;
    MemReady = 1'b0; MemRespValid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lane1_load();
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h100; wd1 = 32'h0; size1 = 3'b010;
    req2 = 1'b0;
    fix_en = 1; fix_data = 32'hDEAD_BEEF;
    run_pair(0, 0, 0, 0, -1, "lane1_load");
    fix_en = 0;
    compared++;
    if (ReadData1 !== 32'hDEAD_BEEF) begin
      mismatched++;
      $display("FAIL lane1_load data got %h exp deadbeef", ReadData1);
    end
    req1 = 1'b0;
  endtask

  task automatic test_dual_store();
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h200; wd1 = $urandom; size1 = 3'd2;
    req2 = 1'b1; we2 = 1'b1; addr2 = 32'h204; wd2 = $urandom; size2 = 3'd0;
    run_pair(0, 0, 0, 0, -1, "dual_store");
    req1 = 1'b0; req2 = 1'b0;
  endtask

  task automatic test_ready_stall();
    req1 = 1'b0;
    req2 = 1'b1; we2 = 1'b0; addr2 = 32'h300; wd2 = $urandom; size2 = 3'd4;
    run_pair(0, 0, 3, 1, -1, "ready_stall");
    req2 = 1'b0;
  endtask

  task automatic test_back_to_back();
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h400; wd1 = $urandom; size1 = 3'd2;
    req2 = 1'b1; we2 = 1'b1; addr2 = 32'h408; wd2 = $urandom; size2 = 3'd1;
    run_pair(0, 0, 0, 0, -1, "b2b_a");
    run_pair(1, 2, 0, 0, -1, "b2b_b");
    req1 = 1'b0; req2 = 1'b0;
  endtask

  task automatic test_drop_req2();
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h500; wd1 = $urandom; size1 = 3'd2;
    req2 = 1'b1; we2 = 1'b0; addr2 = 32'h504; wd2 = $urandom; size2 = 3'd2;
    run_pair(1, 0, 0, 0, 1, "drop_req2");
    req1 = 1'b0; req2 = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) != 0) begin
        req1 = ($urandom_range(0, 3) != 0); we1 = $urandom_range(0, 1) == 1;
        addr1 = $urandom; wd1 = $urandom; size1 = 3'($urandom_range(0, 7));
        req2 = ($urandom_range(0, 3) != 0); we2 = $urandom_range(0, 1) == 1;
        addr2 = $urandom; wd2 = $urandom; size2 = 3'($urandom_range(0, 7));
      end
      run_pair($urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3), -1, "random");
    end
    req1 = 1'b0; req2 = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h600; wd1 = 32'h0; size1 = 3'd2;
    req2 = 1'b0;
    MemReady = 1'b0; MemRespValid = 1'b0;
    tick();
    MemReady = 1'b1;
    #1;
    compared++;
    if (MemValid !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_wait issue MemValid got %b exp 1", MemValid);
    end
    tick();
    MemReady = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if ({MemValid, Done1, Done2, MemAddr, ReadData1, ReadData2} !== 99'd0) begin
      mismatched++;
      $display("FAIL rst_wait async got %b%b%b %h %h %h", MemValid, Done1, Done2,
               MemAddr, ReadData1, ReadData2);
    end
    req1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    MemRespValid = 1'b1;
    MemRData = 32'hCAFE_F00D;
    #1;
    compared++;
    if ({MemValid, Done1, Done2, StallMemory} !== 4'b0000) begin
      mismatched++;
      $display("FAIL rst_wait late resp got %b%b%b%b exp 0000", MemValid,
               Done1, Done2, StallMemory);
    end
    tick();
    MemRespValid = 1'b0;
    rd_exp1 = 32'd0;
    rd_exp2 = 32'd0;
    compared++;
    if ({ReadData1, ReadData2} !== 64'd0) begin
      mismatched++;
      $display("FAIL rst_wait readdata got %h %h exp 0", ReadData1, ReadData2);
    end
    req2 = 1'b1; we2 = 1'b1; addr2 = 32'h700; wd2 = $urandom; size2 = 3'd2;
    #1;
    compared++;
    if (StallMemory !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_wait new req stall got %b exp 1", StallMemory);
    end
    run_pair(0, 0, 0, 0, -1, "post_reset");
    req2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lane1_load();
    test_dual_store();
    test_ready_stall();
    test_back_to_back();
    test_drop_req2();
    test_random();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
